// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin byte scheduler driving an 8N1 UART transmitter
module uart_tx_sched #(
    parameter logic [25:0] BAUD_DIV = 26'd5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       last_gnt
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q;
    logic [25:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        last_gnt_q;

    logic        bit_end;
    logic        sel;

    assign bit_end = (cnt_q == BAUD_DIV - 26'd1);
    // Round-robin only matters under contention; a lone request always wins.
    assign sel     = (req0 && req1) ? ~last_gnt_q : req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            if (state_q != IDLE) begin
                cnt_q <= bit_end ? 26'd0 : cnt_q + 26'd1;
            end
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q    <= START;
                        shift_q    <= sel ? data1 : data0;
                        ack0_q     <= ~sel;
                        ack1_q     <= sel;
                        last_gnt_q <= sel;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    // shift_q[0] is always the bit currently on the line.
                    if (bit_end) begin
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign last_gnt = last_gnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a frame-level reference model
module tb_uart_tx_sched;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, tx, busy, last_gnt;

    uart_tx_sched #(.BAUD_DIV(26'd4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .data0    (data0),
        .ack0     (ack0),
        .req1     (req1),
        .data1    (data1),
        .ack1     (ack1),
        .tx       (tx),
        .busy     (busy),
        .last_gnt (last_gnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         idx;
        logic [7:0] data;
    } item_t;

    item_t exp_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame occupies the line for 10*B cycles after the
    // acceptance edge, then one idle cycle precedes the next acceptance.
    bit         m_free = 1'b1;
    int         m_rem = 0;
    bit         m_last = 1'b1;
    logic [1:0] m_ack = 2'b00;
    bit         m_busy = 1'b0;
    bit         m_g;
    item_t      m_item;

    always @(posedge clk) begin
        if (reset) begin
            m_ack = 2'b00;
            if (!m_free) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_free = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (req0 || req1) begin
                m_g         = (req0 && req1) ? !m_last : req1;
                m_item.idx  = m_g;
                m_item.data = m_g ? data1 : data0;
                exp_q.push_back(m_item);
                m_last = m_g;
                m_ack  = m_g ? 2'b10 : 2'b01;
                m_free = 1'b0;
                m_busy = 1'b1;
                m_rem  = 10 * B;
            end
        end
    end

    // Requesters hold until acknowledged.
    always @(negedge clk) begin
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
    end

    // Monitor: pops an expected frame on each DUT ack, then checks every line cycle.
    logic [7:0] cur_byte = 8'h00;
    int         pos = -1;
    logic       exp_tx;
    item_t      mon_item;

    always @(negedge clk) begin
        if (reset) begin
            check("ack_pair", {6'd0, ack1, ack0}, {6'd0, m_ack});
            check("busy", {7'd0, busy}, {7'd0, m_busy});
            check("last_gnt", {7'd0, last_gnt}, {7'd0, m_last});
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", {6'd0, ack1, ack0}, 8'd0);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("ack_idx", {7'd0, ack1}, {7'd0, mon_item.idx});
                    cur_byte = mon_item.data;
                    pos = 0;
                end
            end
            if (pos < 0) exp_tx = 1'b1;
            else if (pos / B == 0) exp_tx = 1'b0;
            else if (pos / B == 9) exp_tx = 1'b1;
            else exp_tx = cur_byte[pos / B - 1];
            check("tx", {7'd0, tx}, {7'd0, exp_tx});
            if (pos >= 0) begin
                pos++;
                if (pos == 10 * B) pos = -1;
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        m_free = 1'b1;
        m_busy = 1'b0;
        m_ack  = 2'b00;
        m_last = 1'b1;
        m_rem  = 0;
        pos    = -1;
    endtask

    task automatic check_reset_outputs();
        check("rst_tx", {7'd0, tx}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_acks", {6'd0, ack1, ack0}, 8'd0);
        check("rst_last_gnt", {7'd0, last_gnt}, 8'd1);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic reset_pulse();
        @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(req0 == 1'b0 && req1 == 1'b0 && m_free && pos < 0 && exp_q.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 8'd1, 8'd0);
        @(negedge clk);
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (pos != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("pos_timeout", 8'd1, 8'd0);
    endtask

    task automatic wait_ack1();
        int n;
        n = 0;
        while (req1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("ack1_timeout", 8'd1, 8'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #1 reset = 1'b1;

        // Single byte from idle.
        @(negedge clk);
        data0 = 8'hA5; req0 = 1'b1;
        wait_drain();

        // Contention right after reset: requester 0 first, then 1.
        reset_pulse();
        @(negedge clk);
        data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        wait_drain();

        // Requester 1 twice back-to-back.
        data1 = 8'hC3; req1 = 1'b1;
        wait_ack1();
        data1 = 8'h3C; req1 = 1'b1;
        wait_drain();

        // Requester 0 raised mid-frame must wait for the frame to end.
        data1 = 8'h77; req1 = 1'b1;
        wait_pos(2 * B);
        data0 = 8'h96; req0 = 1'b1;
        wait_drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (!req0 && $urandom_range(0, 15) == 0) begin
                data0 = 8'($urandom);
                req0 = 1'b1;
            end
            if (!req1 && $urandom_range(0, 15) == 0) begin
                data1 = 8'($urandom);
                req1 = 1'b1;
            end
        end
        wait_drain();

        // Reset during data bit 3, then a fresh frame.
        data1 = 8'hE1; req1 = 1'b1;
        wait_pos(4 * B + 1);
        reset_pulse();
        @(negedge clk);
        data1 = 8'h5A; req1 = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 26'd5208, meaning clk cycles per serial bit (9600 baud at 50 MHz); legal range 2..2^26-1.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0  input  1  requester 0 byte-send request, held until ack0.
REQ-005 SHALL have port data0  input  8  requester 0 byte, stable while req0 high.
REQ-006 SHALL have port ack0  output  1  one-cycle acceptance pulse to requester 0.
REQ-007 SHALL have port req1  input  1  requester 1 byte-send request, held until ack1.
REQ-008 SHALL have port data1  input  8  requester 1 byte, stable while req1 high.
REQ-009 SHALL have port ack1  output  1  one-cycle acceptance pulse to requester 1.
REQ-010 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port last_gnt  output  1  index of the requester most recently accepted.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL, in IDLE, sample req0/req1 each edge; if either is high, latch the selected byte into an 8-bit shift register, go to START, and register ackN=1 for exactly that next cycle.
REQ-015 SHALL arbitrate round-robin only under contention: both high -> grant the requester not equal to last_gnt; single request -> grant it regardless of last_gnt.
REQ-016 SHALL update last_gnt on the acceptance edge.
REQ-017 SHALL ignore req0/req1 in every state other than IDLE; a request held through a frame is accepted in the first IDLE cycle.
REQ-018 SHALL use a 26-bit bit-period counter, cleared on the acceptance edge, counting 0..BAUD_DIV-1; bit_end = (cnt == BAUD_DIV-1), after which cnt wraps to 0.
REQ-019 SHALL drive tx=0 for BAUD_DIV cycles in START, then enter DATA on bit_end.
REQ-020 SHALL transmit 8 data bits LSB first in DATA, each for BAUD_DIV cycles, with a 3-bit index 0..7; leave DATA on bit_end with index 7.
REQ-021 SHALL drive tx=1 for BAUD_DIV cycles in STOP, then return to IDLE on bit_end.
REQ-022 SHALL drive tx from a register (glitch-free); tx=1 in IDLE and STOP.
REQ-023 SHALL assert busy in START, DATA, STOP; frame length 10*BAUD_DIV cycles; minimum gap between frames one IDLE cycle.
REQ-024 SHALL never assert ack0 and ack1 in the same cycle, and never assert either outside the cycle following acceptance.

Reset
REQ-025 SHALL, on reset low, immediately and asynchronously force state=IDLE, tx=1, busy=0, ack0=ack1=0, counter=0, bit index=0, shift register=0, last_gnt=1 (requester 0 wins first contention).
REQ-026 SHALL abandon any frame in progress on reset with no further line activity; a request pending at reset release is accepted on the first clk edge with reset high.

Verification (BAUD_DIV=4)
REQ-027 SHALL verify: req0 with data0=8'hA5 from idle -> ack0 one cycle; tx 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4; busy high exactly 40 cycles.
REQ-028 SHALL verify: req0 (8'h11) and req1 (8'h22) asserted together after reset -> 8'h11 sent first with ack0, 8'h22 next with ack1, one idle cycle between frames; last_gnt 0 then 1.
REQ-029 SHALL verify: req1 alone issued twice back-to-back -> both accepted via ack1 with no requester-0 slot inserted.
REQ-030 SHALL verify: req0 raised mid-frame -> no ack0 until STOP ends; ack0 in the cycle after the first IDLE cycle.
REQ-031 SHALL verify: reset pulsed low during DATA bit 3 -> tx=1, busy=0, acks 0 with no clk edge; after release, new req1 8'h5A transmits a complete correct frame.
